// File: rtl/if_id_pkg.sv
// Shared definitions for the IF->ID skid stage: FSM state encoding, NOP payload, default widths.
package if_id_pkg;

  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned DEF_CNT_W   = 16;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
    end else if (Inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign Count = r_count;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a 2-entry skid buffer, flush-to-NOP and a stall-cycle counter.
// In_Ready/Out_Valid are registers, so neither depends combinationally on the handshake inputs.
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [INSTR_W-1:0] Instruction_IF,
  input  logic [PC_W-1:0]    PC_Plus_4_IF,
  input  logic               Flush,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [INSTR_W-1:0] Instruction_ID,
  output logic [PC_W-1:0]    PC_Plus_4_ID,
  output logic [CNT_W-1:0]   Stall_Count
);

  state_e             r_state;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  state_e w_next_state;
  logic   w_accept;
  logic   w_consume;
  logic   w_load_main_in;
  logic   w_load_main_skid;
  logic   w_load_skid;
  logic   w_stall;

  assign w_accept  = In_Valid & r_in_ready;
  assign w_consume = r_out_valid & Out_Ready;
  assign w_stall   = r_out_valid & ~Out_Ready;

  // Next state and register load enables; Flush overrides every transition.
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (Flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_next_state   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_load_skid  = 1'b1;
            w_next_state = ST_TWO;
          end else if (w_consume) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_consume) begin
            w_load_main_skid = 1'b1;
            w_next_state     = ST_ONE;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_instr <= INSTR_W'(NOP_INSTR);
      r_main_pc    <= '0;
      r_skid_instr <= INSTR_W'(NOP_INSTR);
      r_skid_pc    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_out_valid <= (w_next_state != ST_EMPTY);
      r_in_ready  <= (w_next_state != ST_TWO);
      if (Flush) begin
        r_main_instr <= INSTR_W'(NOP_INSTR);
        r_main_pc    <= '0;
        r_skid_instr <= INSTR_W'(NOP_INSTR);
        r_skid_pc    <= '0;
      end else begin
        if (w_load_main_in) begin
          r_main_instr <= Instruction_IF;
          r_main_pc    <= PC_Plus_4_IF;
        end else if (w_load_main_skid) begin
          r_main_instr <= r_skid_instr;
          r_main_pc    <= r_skid_pc;
        end
        if (w_load_skid) begin
          r_skid_instr <= Instruction_IF;
          r_skid_pc    <= PC_Plus_4_IF;
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (w_stall),
    .Count (Stall_Count)
  );

  assign Out_Valid      = r_out_valid;
  assign In_Ready       = r_in_ready;
  assign Instruction_ID = r_main_instr;
  assign PC_Plus_4_ID   = r_main_pc;

endmodule
